// File: rtl/ysyx_23060184_ifu.sv
// Instruction fetch unit: holds the PC, fetches one word per instruction and hands it to decode.
// Optional feature: define YSYX_23060184_IFU_MISALIGN_CHECK_EN to fault misaligned PCs without a bus request.
module ysyx_23060184_ifu #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] npc,
  input  logic                  Pready,
  input  logic                  Dready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [DATA_WIDTH-1:0] PC,
  output logic                  Ivalid,
  output logic                  Ifault,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  imem_rsp_err
);

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

`ifdef YSYX_23060184_IFU_MISALIGN_CHECK_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_NEXT = 2'd3
  } state_t;

  state_t                state;
  logic                  pend_valid;
  logic [DATA_WIDTH-1:0] pend_pc;

  function automatic logic misaligned(input logic [DATA_WIDTH-1:0] addr);
    return MISALIGN_EN && (addr[1:0] != 2'b00);
  endfunction

  // The low PC bits never reach the bus; without the check they are simply ignored.
  assign imem_addr = {PC[DATA_WIDTH-1:2], 2'b00};

  // NOTE: all state, including the outputs, is updated with non-blocking
  // assignments so every register sees pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= S_REQ;
      PC             <= RESET_PC[DATA_WIDTH-1:0];
      inst           <= NOP;
      Ivalid         <= 1'b0;
      Ifault         <= 1'b0;
      imem_req_valid <= 1'b0;
      pend_valid     <= 1'b0;
      pend_pc        <= '0;
    end else begin
      // Next-PC pulses that arrive before decode has consumed the word are parked.
      if (Pready && state != S_NEXT) begin
        pend_valid <= 1'b1;
        pend_pc    <= npc;
      end

      case (state)
        S_REQ: begin
          imem_req_valid <= !misaligned(PC);
          if (misaligned(PC)) begin
            state          <= S_HOLD;
            inst           <= NOP;
            Ifault         <= 1'b1;
            Ivalid         <= 1'b1;
            imem_req_valid <= 1'b0;
          end else if (imem_req_valid && imem_req_ready) begin
            state          <= S_WAIT;
            imem_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            state  <= S_HOLD;
            inst   <= imem_rsp_err ? NOP : imem_rsp_data;
            Ifault <= imem_rsp_err;
            Ivalid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (Dready) begin
            state  <= S_NEXT;
            Ivalid <= 1'b0;
          end
        end
        S_NEXT: begin
          // A live pulse beats a stale parked value.
          if (Pready) begin
            state          <= S_REQ;
            PC             <= npc;
            Ifault         <= 1'b0;
            pend_valid     <= 1'b0;
            imem_req_valid <= !misaligned(npc);
          end else if (pend_valid) begin
            state          <= S_REQ;
            PC             <= pend_pc;
            Ifault         <= 1'b0;
            pend_valid     <= 1'b0;
            imem_req_valid <= !misaligned(pend_pc);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060184_ifu.sv
// Directed self-checking bench for ysyx_23060184_ifu; follows the FSM cycle by cycle.
module tb_ysyx_23060184_ifu;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] npc;
  logic        Pready, Dready;
  logic [31:0] inst, PC, imem_addr, imem_rsp_data;
  logic        Ivalid, Ifault, imem_req_valid, imem_req_ready, imem_rsp_valid, imem_rsp_err;

  int tests = 0;
  int fails = 0;

  ysyx_23060184_ifu dut (
    .clk(clk), .rstn(rstn), .npc(npc), .Pready(Pready), .Dready(Dready),
    .inst(inst), .PC(PC), .Ivalid(Ivalid), .Ifault(Ifault),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; npc = '0; Pready = 0; Dready = 0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0; imem_rsp_err = 0;
    tick(); tick();
    tests++; if (PC !== 32'h8000_0000) begin fails++; $display("FAIL rst_pc: got %h want 80000000", PC); end
    tests++; if (inst !== 32'h0000_0013) begin fails++; $display("FAIL rst_inst: got %h want 00000013", inst); end
    tests++; if (Ivalid !== 1'b0 || Ifault !== 1'b0) begin fails++; $display("FAIL rst_flags: got %b%b want 00", Ivalid, Ifault); end
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", imem_req_valid); end
    rstn = 1'b1;
    tick();  // cycle 1
    tests++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8000_0000) begin fails++; $display("FAIL c1_req: got %b %h want 1 80000000", imem_req_valid, imem_addr); end
    imem_req_ready = 1;
    tick();  // cycle 2
    tests++; if (imem_req_valid !== 1'b0 || Ivalid !== 1'b0) begin fails++; $display("FAIL c2_wait: got req %b ivalid %b want 0 0", imem_req_valid, Ivalid); end
    imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h0010_0093;
    tick();  // cycle 3
    imem_rsp_valid = 0;
    tests++; if (Ivalid !== 1'b1 || inst !== 32'h0010_0093 || PC !== 32'h8000_0000) begin fails++; $display("FAIL c3_hold: got %b %h %h want 1 00100093 80000000", Ivalid, inst, PC); end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++; if (Ivalid !== 1'b1 || inst !== 32'h0010_0093) begin fails++; $display("FAIL hold_stable[%0d]: got %b %h want 1 00100093", i, Ivalid, inst); end
    end
    Dready = 1;
    tick();
    Dready = 0;
    tests++; if (Ivalid !== 1'b0) begin fails++; $display("FAIL hold_release: got %b want 0", Ivalid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL next_idle[%0d]: got %b want 0", i, imem_req_valid); end
    end
    Pready = 1; npc = 32'h8000_0004;
    tick();
    Pready = 0;
    tests++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8000_0004 || PC !== 32'h8000_0004) begin fails++; $display("FAIL next_req: got %b %h %h want 1 80000004 80000004", imem_req_valid, imem_addr, PC); end
  endtask

  task automatic test_early_pready();
    imem_req_ready = 1;
    tick();
    imem_req_ready = 0;
    Pready = 1; npc = 32'h8000_0010;
    imem_rsp_valid = 1; imem_rsp_data = 32'h0020_0113;
    tick();
    Pready = 0; imem_rsp_valid = 0;
    tests++; if (Ivalid !== 1'b1 || inst !== 32'h0020_0113 || PC !== 32'h8000_0004) begin fails++; $display("FAIL early_hold: got %b %h %h want 1 00200113 80000004", Ivalid, inst, PC); end
    Dready = 1;
    tick();
    Dready = 0;
    tests++; if (Ivalid !== 1'b0 || imem_req_valid !== 1'b0) begin fails++; $display("FAIL early_next: got %b %b want 0 0", Ivalid, imem_req_valid); end
    tick();
    tests++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8000_0010) begin fails++; $display("FAIL early_addr: got %b %h want 1 80000010", imem_req_valid, imem_addr); end
  endtask

  task automatic test_fault_and_precedence();
    imem_req_ready = 1;
    tick();
    imem_req_ready = 0;
    imem_rsp_valid = 1; imem_rsp_err = 1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 0; imem_rsp_err = 0;
    tests++; if (inst !== 32'h0000_0013 || Ifault !== 1'b1 || Ivalid !== 1'b1) begin fails++; $display("FAIL err_rsp: got %h %b %b want 00000013 1 1", inst, Ifault, Ivalid); end
    // Park a stale value while holding, then override it with a live pulse in NEXT.
    Pready = 1; npc = 32'h8000_0030;
    tick();
    Pready = 0; Dready = 1;
    tick();
    Dready = 0; Pready = 1; npc = 32'h8000_0020;
    tick();
    Pready = 0;
    tests++; if (PC !== 32'h8000_0020 || Ifault !== 1'b0 || imem_req_valid !== 1'b1) begin fails++; $display("FAIL live_wins: got %h %b %b want 80000020 0 1", PC, Ifault, imem_req_valid); end
    imem_req_ready = 1;
    tick();
    imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h0030_0193;
    tick();
    imem_rsp_valid = 0; Dready = 1;
    tick();
    Dready = 0;
    tick(); tick();
    tests++; if (imem_req_valid !== 1'b0 || PC !== 32'h8000_0020) begin fails++; $display("FAIL pend_cleared: got %b %h want 0 80000020", imem_req_valid, PC); end
  endtask

  task automatic test_misalign();
    Pready = 1; npc = 32'h8000_0002;
    tick();
    Pready = 0;
`ifdef YSYX_23060184_IFU_MISALIGN_CHECK_EN
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL mis_noreq: got %b want 0", imem_req_valid); end
    tick();
    tests++; if (Ifault !== 1'b1 || inst !== 32'h0000_0013 || Ivalid !== 1'b1 || imem_req_valid !== 1'b0) begin fails++; $display("FAIL mis_fault: got %b %h %b %b want 1 00000013 1 0", Ifault, inst, Ivalid, imem_req_valid); end
`else
    tests++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8000_0000) begin fails++; $display("FAIL mis_aligned: got %b %h want 1 80000000", imem_req_valid, imem_addr); end
    imem_req_ready = 1;
    tick();
    imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h0040_0213;
    tick();
    imem_rsp_valid = 0;
    tests++; if (Ifault !== 1'b0 || inst !== 32'h0040_0213 || PC !== 32'h8000_0002) begin fails++; $display("FAIL mis_fetch: got %b %h %h want 0 00400213 80000002", Ifault, inst, PC); end
`endif
    Dready = 1;
    tick();
    Dready = 0; Pready = 1; npc = 32'h8000_0040;
    tick();
    Pready = 0;
    tests++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8000_0040 || Ifault !== 1'b0) begin fails++; $display("FAIL mis_recover: got %b %h %b want 1 80000040 0", imem_req_valid, imem_addr, Ifault); end
  endtask

  task automatic test_reset_mid();
    imem_req_ready = 1;
    tick();
    imem_req_ready = 0;
    rstn = 0;
    tick();
    rstn = 1;
    tests++; if (Ivalid !== 1'b0 || imem_req_valid !== 1'b0 || PC !== 32'h8000_0000) begin fails++; $display("FAIL midrst: got %b %b %h want 0 0 80000000", Ivalid, imem_req_valid, PC); end
    imem_rsp_valid = 1; imem_rsp_data = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++; if (Ivalid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h8000_0000) begin fails++; $display("FAIL late_drop[%0d]: got %b %b %h want 0 1 80000000", i, Ivalid, imem_req_valid, imem_addr); end
    end
    imem_rsp_valid = 0;
    tests++; if (inst !== 32'h0000_0013) begin fails++; $display("FAIL late_inst: got %h want 00000013", inst); end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_early_pready();
    test_fault_and_precedence();
    test_misalign();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
